// File: rtl/uart_pkg.sv
// Shared UART parity definitions: parity-mode encodings and checker FSM states.
package uart_pkg;

  localparam logic [1:0] PAR_EVEN  = 2'b00;
  localparam logic [1:0] PAR_ODD   = 2'b01;
  localparam logic [1:0] PAR_SPACE = 2'b10;
  localparam logic [1:0] PAR_MARK  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_PBIT  = 2'd2
  } chk_state_e;

endpackage

// File: rtl/parity_calc.sv
// Combinational parity of a word under a given mode.
// With W=1 it passes a pre-accumulated parity through (even) or forces mark/space.
module parity_calc
  import uart_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] word,
  input  logic         en,
  input  logic [1:0]   mode,
  output logic         par
);

  // Select the parity rule; disabled parity always yields 0
  always_comb begin
    par = 1'b0;
    if (en) begin
      case (mode)
        PAR_EVEN:  par = ^word;
        PAR_ODD:   par = ~(^word);
        PAR_SPACE: par = 1'b0;
        default:   par = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/uart_parity_unit.sv
// Registered parity generator (parallel word) and serial parity checker
// shared by the UART transmit and receive paths.
module uart_parity_unit
  import uart_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [DATA_W-1:0] P_Data,
  input  logic              Data_Valid,
  input  logic              Par_En,
  input  logic [1:0]        Parity_Ty,
  output logic              Par_bit,
  output logic              Par_Ready,
  input  logic              Chk_Start,
  input  logic              Ser_Bit,
  input  logic              Bit_Valid,
  output logic              Par_Err,
  output logic              Chk_Done,
  output logic              Chk_Busy
);

  // ---------------- generator ----------------
  logic gen_par;
  logic par_bit_q, par_bit_d;
  logic ready_q, ready_d;

  parity_calc #(.W(DATA_W)) u_gen_calc (
    .word (P_Data),
    .en   (Par_En),
    .mode (Parity_Ty),
    .par  (gen_par)
  );

  // Capture parity on each Data_Valid; hold it otherwise
  always_comb begin
    par_bit_d = par_bit_q;
    ready_d   = ready_q;
    if (Data_Valid) begin
      par_bit_d = gen_par;
      ready_d   = 1'b1;
    end
  end

  // ---------------- checker ----------------
  chk_state_e       state_q, state_d;
  logic             acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             en_q, en_d;
  logic [1:0]       ty_q, ty_d;
  logic             err_q, err_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             exp_bit;
  logic [1:0]       exp_mode;
  logic             last_bit;

  // Odd inversion is already folded into the accumulator seed, so odd
  // collapses to even when deriving the expected bit from acc.
  assign exp_mode = (ty_q == PAR_ODD) ? PAR_EVEN : ty_q;
  assign last_bit = (cnt_q == CNT_W'(DATA_W - 1));

  parity_calc #(.W(1)) u_exp_calc (
    .word (acc_q),
    .en   (1'b1),
    .mode (exp_mode),
    .par  (exp_bit)
  );

  // Checker next-state: Chk_Start restarts from any state and beats Bit_Valid
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    en_d    = en_q;
    ty_d    = ty_q;
    err_d   = 1'b0;
    done_d  = 1'b0;
    if (Chk_Start) begin
      state_d = ST_ACCUM;
      acc_d   = (Parity_Ty == PAR_ODD);
      cnt_d   = '0;
      en_d    = Par_En;
      ty_d    = Parity_Ty;
    end else begin
      case (state_q)
        ST_ACCUM: begin
          if (Bit_Valid) begin
            acc_d = acc_q ^ Ser_Bit;
            cnt_d = cnt_q + CNT_W'(1);
            if (last_bit) begin
              if (en_q) begin
                state_d = ST_PBIT;
              end else begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
              end
            end
          end
        end
        ST_PBIT: begin
          if (Bit_Valid) begin
            state_d = ST_IDLE;
            err_d   = (Ser_Bit != exp_bit);
            done_d  = 1'b1;
          end
        end
        default: ;
      endcase
    end
    busy_d = (state_d != ST_IDLE);
  end

  // All state registers; synchronous active-low reset has top priority
  always_ff @(posedge CLK) begin
    if (!RST) begin
      par_bit_q <= 1'b0;
      ready_q   <= 1'b0;
      state_q   <= ST_IDLE;
      acc_q     <= 1'b0;
      cnt_q     <= '0;
      en_q      <= 1'b0;
      ty_q      <= PAR_EVEN;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      par_bit_q <= par_bit_d;
      ready_q   <= ready_d;
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      en_q      <= en_d;
      ty_q      <= ty_d;
      err_q     <= err_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  assign Par_bit   = par_bit_q;
  assign Par_Ready = ready_q;
  assign Par_Err   = err_q;
  assign Chk_Done  = done_q;
  assign Chk_Busy  = busy_q;

endmodule

// File: tb/tb_uart_parity_unit.sv
// Self-checking bench for uart_parity_unit (DATA_W=8).
module tb_uart_parity_unit;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] P_Data;
  logic       Data_Valid;
  logic       Par_En;
  logic [1:0] Parity_Ty;
  logic       Par_bit;
  logic       Par_Ready;
  logic       Chk_Start;
  logic       Ser_Bit;
  logic       Bit_Valid;
  logic       Par_Err;
  logic       Chk_Done;
  logic       Chk_Busy;

  int tests = 0;
  int fails = 0;

  logic gen_q[$];
  logic chk_q[$];

  always #5 CLK = ~CLK;

  uart_parity_unit #(.DATA_W(8), .CNT_W(4)) dut (
    .CLK(CLK), .RST(RST), .P_Data(P_Data), .Data_Valid(Data_Valid),
    .Par_En(Par_En), .Parity_Ty(Parity_Ty), .Par_bit(Par_bit),
    .Par_Ready(Par_Ready), .Chk_Start(Chk_Start), .Ser_Bit(Ser_Bit),
    .Bit_Valid(Bit_Valid), .Par_Err(Par_Err), .Chk_Done(Chk_Done),
    .Chk_Busy(Chk_Busy)
  );

  typedef struct {
    logic [7:0] data;
    logic       en;
    logic [1:0] ty;
    logic       exp;
  } gen_vec_t;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  function automatic logic model_par(input logic [7:0] d, input logic en, input logic [1:0] ty);
    if (!en) return 1'b0;
    case (ty)
      2'b00:   return ^d;
      2'b01:   return ~(^d);
      2'b10:   return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

  // Checker scoreboard: every Chk_Done pops one expected Par_Err
  always @(negedge CLK) begin
    if (RST === 1'b1) begin
      if (Chk_Done === 1'b1) begin
        if (chk_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL chk_unexpected_done: got Chk_Done=1 expected none");
        end else begin
          logic e;
          e = chk_q.pop_front();
          check("chk_par_err", Par_Err, e);
          check("chk_busy_at_done", Chk_Busy, 1'b0);
        end
      end else if (Par_Err === 1'b1) begin
        tests++; fails++;
        $display("FAIL chk_err_without_done: got Par_Err=1 expected 0");
      end
    end
  end

  // Full receive frame: start, n data bits LSB first, optional parity bit
  task automatic frame(input logic [7:0] d, input logic en, input logic [1:0] ty,
                       input logic pbit, input logic start_with_bv);
    Par_En = en; Parity_Ty = ty;
    Chk_Start = 1'b1; Bit_Valid = start_with_bv; Ser_Bit = 1'b1;
    tick();
    Chk_Start = 1'b0;
    check("chk_busy_after_start", Chk_Busy, 1'b1);
    for (int i = 0; i < 8; i++) begin
      Bit_Valid = 1'b1; Ser_Bit = d[i];
      if (i == 7 && !en) chk_q.push_back(1'b0);
      tick();
    end
    if (en) begin
      Bit_Valid = 1'b1; Ser_Bit = pbit;
      chk_q.push_back(pbit != model_par(d, 1'b1, ty));
      tick();
    end else begin
      check("chk_noparity_done_timing", Chk_Done, 1'b1);
    end
    Bit_Valid = 1'b0;
    tick(); tick();
  endtask

  gen_vec_t vecs[8];
  logic last_exp;

  initial begin
    vecs[0] = '{8'hA5, 1'b1, 2'b00, 1'b0};
    vecs[1] = '{8'hA5, 1'b1, 2'b01, 1'b1};
    vecs[2] = '{8'h07, 1'b1, 2'b00, 1'b1};
    vecs[3] = '{8'h00, 1'b1, 2'b11, 1'b1};
    vecs[4] = '{8'hFF, 1'b1, 2'b10, 1'b0};
    vecs[5] = '{8'h07, 1'b0, 2'b01, 1'b0};
    vecs[6] = '{8'hFF, 1'b1, 2'b01, 1'b1};
    vecs[7] = '{8'h01, 1'b1, 2'b00, 1'b1};

    RST = 1'b0; P_Data = 8'h00; Data_Valid = 1'b0; Par_En = 1'b1; Parity_Ty = 2'b00;
    Chk_Start = 1'b0; Ser_Bit = 1'b0; Bit_Valid = 1'b0;

    // Reset with toggling inputs
    for (int i = 0; i < 2; i++) begin
      P_Data = 8'h5A ^ 8'(i); Data_Valid = 1'b1; Chk_Start = 1'b1;
      Bit_Valid = 1'b1; Ser_Bit = 1'(i);
      tick();
    end
    check("rst_par_bit", Par_bit, 1'b0);
    check("rst_par_ready", Par_Ready, 1'b0);
    check("rst_par_err", Par_Err, 1'b0);
    check("rst_chk_done", Chk_Done, 1'b0);
    check("rst_chk_busy", Chk_Busy, 1'b0);
    Data_Valid = 1'b0; Chk_Start = 1'b0; Bit_Valid = 1'b0;
    RST = 1'b1;
    tick();

    // Generator table, applied back to back
    foreach (vecs[i]) begin
      P_Data = vecs[i].data; Par_En = vecs[i].en; Parity_Ty = vecs[i].ty;
      Data_Valid = 1'b1;
      gen_q.push_back(model_par(vecs[i].data, vecs[i].en, vecs[i].ty));
      tick();
      last_exp = gen_q.pop_front();
      if (vecs[i].exp !== last_exp) begin
        tests++; fails++;
        $display("FAIL gen_table_model[%0d]: table %b model %b", i, vecs[i].exp, last_exp);
      end
      check("gen_par_bit", Par_bit, vecs[i].exp);
      check("gen_par_ready", Par_Ready, 1'b1);
    end
    Data_Valid = 1'b0;

    // Inputs changing without Data_Valid must not disturb Par_bit
    P_Data = 8'h00; Parity_Ty = 2'b01; Par_En = 1'b1;
    tick(); tick();
    check("gen_hold", Par_bit, last_exp);
    check("gen_ready_hold", Par_Ready, 1'b1);

    // Checker frames
    frame(8'h07, 1'b1, 2'b00, 1'b1, 1'b0);  // good even
    frame(8'h07, 1'b1, 2'b00, 1'b0, 1'b0);  // bad even
    frame(8'h07, 1'b1, 2'b01, 1'b0, 1'b0);  // good odd
    frame(8'hA5, 1'b1, 2'b11, 1'b0, 1'b0);  // bad mark
    frame(8'h3C, 1'b0, 2'b00, 1'b0, 1'b0);  // parity disabled
    frame(8'h00, 1'b1, 2'b00, 1'b0, 1'b1);  // start beats Bit_Valid

    // Abort after 4 bits, then a full 8'hFF even frame
    Par_En = 1'b1; Parity_Ty = 2'b01;
    Chk_Start = 1'b1; tick(); Chk_Start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      Bit_Valid = 1'b1; Ser_Bit = 1'b1; tick();
    end
    Bit_Valid = 1'b0;
    frame(8'hFF, 1'b1, 2'b00, 1'b0, 1'b0);

    // Reset mid-frame: no Chk_Done may follow
    Chk_Start = 1'b1; tick(); Chk_Start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      Bit_Valid = 1'b1; Ser_Bit = 1'b1; tick();
    end
    Bit_Valid = 1'b0;
    RST = 1'b0; tick();
    check("rst_mid_busy", Chk_Busy, 1'b0);
    check("rst_mid_ready", Par_Ready, 1'b0);
    RST = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    check("rst_mid_still_idle", Chk_Busy, 1'b0);

    tests++;
    if (chk_q.size() != 0) begin
      fails++;
      $display("FAIL chk_missing_done: got %0d outstanding expected 0", chk_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_parity_unit.md
Name: uart_parity_unit

Overview:
- Parametrised, registered parity block shared by the UART transmit and receive paths.
- Generator path: latches a parallel word on Data_Valid and produces a held parity bit one cycle later, for the framer to send.
- Checker path: accumulates parity serially as the receiver samples data bits, then compares it against the received parity bit and flags errors.
- Supports even, odd, mark, space and disabled parity; word width is a parameter.

Parameters:
- DATA_W, 8, data bits per frame; legal range 5..9.
- CNT_W, 4, width of the checker bit counter; must satisfy 2^CNT_W > DATA_W.

Ports:
- CLK  in  1  system clock; all state changes on the rising edge.
- RST  in  1  synchronous active-low reset.
- P_Data  in  DATA_W  parallel word for the generator.
- Data_Valid  in  1  single-cycle pulse; P_Data is valid.
- Par_En  in  1  1 = parity enabled; 0 = no parity bit.
- Parity_Ty  in  2  parity mode: 00 even, 01 odd, 10 space (constant 0), 11 mark (constant 1).
- Par_bit  out  1  generated parity bit; held until the next capture.
- Par_Ready  out  1  1 from the cycle after a capture until the next Data_Valid.
- Chk_Start  in  1  pulse marking the start of a receive frame.
- Ser_Bit  in  1  sampled serial bit.
- Bit_Valid  in  1  Ser_Bit is valid this cycle.
- Par_Err  out  1  one-cycle pulse: parity mismatch.
- Chk_Done  out  1  one-cycle pulse: parity bit consumed, or frame finished when parity is disabled.
- Chk_Busy  out  1  checker is in ACCUM or PBIT.

Behaviour:
Reset:
- RST=0 at a clock edge clears all outputs to 0 and returns the checker to IDLE.
- Reset takes priority over every other input, mid-frame included.

Generator path:
- Data_Valid=1 at edge N: P_Data, Par_En and Parity_Ty are registered.
- At N+1, Par_bit and Par_Ready=1 become valid (latency 1 cycle).
- Parity rule:
  - even: Par_bit = XOR of the captured word.
  - odd: Par_bit = inverted XOR.
  - space: 0.
  - mark: 1.
  - Par_En=0: Par_bit=0, Par_Ready still asserts.
- Changes on P_Data or Parity_Ty while Data_Valid=0 do not affect Par_bit.
- Back-to-back Data_Valid pulses: each new word overwrites the last. Par_Ready stays 1 throughout; Par_bit updates one cycle after each pulse.

Checker path, 3-state FSM IDLE / ACCUM / PBIT:
- Mode is latched on Chk_Start and does not change mid-frame.
- IDLE:
  - Chk_Start=1 → ACCUM.
  - Accumulator cleared to 0 for even/space/mark, 1 for odd.
  - Counter cleared; Par_En and Parity_Ty latched.
- ACCUM:
  - Each Bit_Valid: acc ^= Ser_Bit; cnt++.
  - On the DATA_W-th bit (cnt == DATA_W-1 while Bit_Valid):
    - Par_En=1 → PBIT.
    - Par_En=0 → IDLE with Chk_Done=1 next cycle and Par_Err=0.
- PBIT:
  - On Bit_Valid, compute expected = acc for even/odd, 0 for space, 1 for mark.
  - Next cycle: Par_Err = (Ser_Bit != expected) and Chk_Done=1 (both one cycle).
  - FSM → IDLE.
- Chk_Start in ACCUM or PBIT aborts the frame and restarts it:
  - Accumulator and counter are re-initialised, config re-latched, stays/goes to ACCUM.
  - No Chk_Done or Par_Err for the aborted frame.
- Chk_Start and Bit_Valid in the same cycle: the start wins and that Bit_Valid is ignored.
- Bit_Valid in IDLE is ignored.
- Chk_Busy = (state != IDLE), registered.
- Generator and checker are independent and may operate in the same cycle.

Decomposition:
- Shared package uart_pkg:
  - parity-mode constants PAR_EVEN=2'b00, PAR_ODD=2'b01, PAR_SPACE=2'b10, PAR_MARK=2'b11.
  - checker state encodings ST_IDLE, ST_ACCUM, ST_PBIT.
- One natural sub-module: parity_calc, a combinational (word, mode) → bit function.
  - Used by the generator and, in degenerate form, for the checker's expected bit.

Test Plan:
1. Reset: hold RST=0 for 2 cycles with toggling inputs → Par_bit=0, Par_Ready=0, Par_Err=0, Chk_Done=0, Chk_Busy=0.
2. Generator, DATA_W=8:
   - P_Data=8'hA5, Data_Valid pulse, even → Par_bit=0 one cycle later.
   - Repeat with odd → Par_bit=1.
   - 8'h07 even → 1.
   - Mark → 1; space → 0.
3. Checker good frame: Chk_Start, serial bits of 8'h07 LSB-first, then parity bit 1, even → Chk_Done pulses 1 cycle with Par_Err=0; Chk_Busy drops the same cycle.
4. Checker bad frame: same frame with parity bit 0 → Par_Err=1 and Chk_Done=1 for exactly one cycle.
5. Parity disabled: Par_En=0, 8 data bits → Chk_Done the cycle after the 8th bit, FSM never enters PBIT, Par_Err=0.
6. Abort and reset mid-frame:
   - Chk_Start after 4 bits, then a full 8'hFF frame with even parity bit 0 → Par_Err=0, exactly one Chk_Done.
   - RST=0 after 3 bits → Chk_Busy=0 next cycle, no Chk_Done.
